// File: rtl/piso_serial_tx.sv
// -----------------------------------------------------------------------------
// piso_serial_tx
//   Parallel-in / serial-out framed transmitter. One data word is taken per
//   valid/ready handshake and sent as a frame:
//     start (0) | data bits | optional even parity | stop (1)
//   Every serial bit is held on sout for clks_per_bit clock cycles.
//
// Parameters
//   data_bitsize : width of the data word (>= 2)
//   clks_per_bit : clock cycles each serial bit is held (>= 1)
//   parity_en    : 1 = append an even-parity bit after the data, 0 = none
//
// Ports
//   clk       : clock, all flops update on the rising edge
//   reset     : synchronous, active-high; aborts any frame in progress
//   din       : parallel word to transmit
//   din_valid : din is valid this cycle
//   din_ready : block can accept a word this cycle (combinational)
//   msb_first : bit order, sampled at accept (1 = MSB first)
//   sout      : registered serial output, idles high
//   busy      : registered, high while a frame is on the line
//   tx_done   : registered one-cycle pulse in the IDLE cycle after a frame
// -----------------------------------------------------------------------------
module piso_serial_tx #(
    parameter int data_bitsize = 4,
    parameter int clks_per_bit = 1,
    parameter int parity_en    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [data_bitsize-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    msb_first,
    output logic                    sout,
    output logic                    busy,
    output logic                    tx_done
);

    localparam int CW = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int BW = (data_bitsize > 1) ? $clog2(data_bitsize) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(clks_per_bit - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(data_bitsize - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cyc, cyc_nxt;
    logic [BW-1:0]           bitc, bit_nxt;
    logic [data_bitsize-1:0] sh, sh_nxt;
    logic                    par, par_nxt;
    logic                    sout_nxt, busy_nxt, done_nxt;
    logic                    accept, cyc_last, bit_last;

    // The shifter always emits from bit 0, so an MSB-first word is stored
    // reversed at accept time and the datapath never cares about the order.
    function automatic logic [data_bitsize-1:0] bit_reverse(
        input logic [data_bitsize-1:0] v
    );
        logic [data_bitsize-1:0] r;
        for (int i = 0; i < data_bitsize; i++) begin
            r[i] = v[data_bitsize-1-i];
        end
        return r;
    endfunction

    assign din_ready = (state == IDLE) && !reset;
    assign accept    = din_valid && din_ready;
    assign cyc_last  = (cyc == CYC_LAST);
    assign bit_last  = (bitc == BIT_LAST);

    // sout is registered, so the combinational block computes the value the
    // line must carry in the *next* state and the flop presents it one edge
    // later, exactly aligned with the state it belongs to.
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        bit_nxt   = bitc;
        sh_nxt    = sh;
        par_nxt   = par;
        sout_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (accept) begin
                    state_nxt = START;
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    sh_nxt    = msb_first ? bit_reverse(din) : din;
                    par_nxt   = ^din;
                    sout_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end

            START: begin
                sout_nxt = 1'b0;
                if (cyc_last) begin
                    state_nxt = DATA;
                    cyc_nxt   = '0;
                    sout_nxt  = sh[0];
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end

            DATA: begin
                sout_nxt = sh[0];
                if (cyc_last) begin
                    cyc_nxt = '0;
                    if (bit_last) begin
                        bit_nxt = '0;
                        if (parity_en != 0) begin
                            state_nxt = PARITY;
                            sout_nxt  = par;
                        end else begin
                            state_nxt = STOP;
                            sout_nxt  = 1'b1;
                        end
                    end else begin
                        bit_nxt  = bitc + BW'(1);
                        sh_nxt   = sh >> 1;
                        // next bit is the one about to land in sh[0]
                        sout_nxt = sh[1];
                    end
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end

            PARITY: begin
                sout_nxt = par;
                if (cyc_last) begin
                    state_nxt = STOP;
                    cyc_nxt   = '0;
                    sout_nxt  = 1'b1;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end

            STOP: begin
                sout_nxt = 1'b1;
                if (cyc_last) begin
                    state_nxt = IDLE;
                    cyc_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc     <= '0;
            bitc    <= '0;
            sh      <= '0;
            par     <= 1'b0;
            sout    <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc     <= cyc_nxt;
            bitc    <= bit_nxt;
            sh      <= sh_nxt;
            par     <= par_nxt;
            sout    <= sout_nxt;
            busy    <= busy_nxt;
            tx_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_serial_tx
//   Two instances: dut_a with the default configuration (4 bits, 1 clk/bit,
//   parity on) and dut_b with 3 clks/bit and no parity. Expected serial
//   waveforms come from a frame model that lists the frame bits and repeats
//   each one clks_per_bit times. Outputs are sampled on the falling edge and
//   inputs are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_piso_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_a, din_valid_a, msb_a, ready_a, sout_a, busy_a, done_a;
    logic [3:0] din_a;
    logic       reset_b, din_valid_b, msb_b, ready_b, sout_b, busy_b, done_b;
    logic [3:0] din_b;

    int n_checks = 0;
    int n_fail   = 0;

    piso_serial_tx #(.data_bitsize(4), .clks_per_bit(1), .parity_en(1)) dut_a (
        .clk(clk), .reset(reset_a), .din(din_a), .din_valid(din_valid_a),
        .din_ready(ready_a), .msb_first(msb_a), .sout(sout_a),
        .busy(busy_a), .tx_done(done_a)
    );

    piso_serial_tx #(.data_bitsize(4), .clks_per_bit(3), .parity_en(0)) dut_b (
        .clk(clk), .reset(reset_b), .din(din_b), .din_valid(din_valid_b),
        .din_ready(ready_b), .msb_first(msb_b), .sout(sout_b),
        .busy(busy_b), .tx_done(done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Frame model: start 0, data in the requested order, optional even
    // parity, stop 1; each bit repeated c times. len returns cycle count.
    function automatic logic [63:0] frame_bits(input logic [3:0] d, input logic m,
                                               input int c, input int p,
                                               output int len);
        logic [7:0]  seq;
        int          n;
        logic [63:0] r;
        seq = '0;
        seq[0] = 1'b0;
        for (int i = 0; i < 4; i++) seq[1+i] = m ? d[3-i] : d[i];
        n = 5;
        if (p != 0) begin
            seq[n] = ^d;
            n = n + 1;
        end
        seq[n] = 1'b1;
        n = n + 1;
        r   = '0;
        len = 0;
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < c; k++) begin
                r[len] = seq[b];
                len    = len + 1;
            end
        end
        return r;
    endfunction

    // Starts in a cycle where dut_a should be ready; ends in the tx_done
    // cycle with inputs still driven as during the frame.
    task automatic frame_a(input logic [3:0] d, input logic m, input logic bv,
                           input logic [3:0] bd, input string tag);
        logic [63:0] e;
        int          len;
        e = frame_bits(d, m, 1, 1, len);
        chk({tag, " ready_pre"}, ready_a, 1'b1);
        din_a = d; msb_a = m; din_valid_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s sout[%0d]", tag, i), sout_a, e[i]);
            chk($sformatf("%s busy[%0d]", tag, i), busy_a, 1'b1);
            chk($sformatf("%s ready[%0d]", tag, i), ready_a, 1'b0);
            chk($sformatf("%s done[%0d]", tag, i), done_a, 1'b0);
            din_valid_a = bv; din_a = bd; msb_a = ~m;
            @(negedge clk);
        end
        chk({tag, " done"}, done_a, 1'b1);
        chk({tag, " busy_end"}, busy_a, 1'b0);
        chk({tag, " ready_end"}, ready_a, 1'b1);
        chk({tag, " sout_end"}, sout_a, 1'b1);
    endtask

    task automatic frame_b(input logic [3:0] d, input logic m, input string tag);
        logic [63:0] e;
        int          len;
        e = frame_bits(d, m, 3, 0, len);
        chk({tag, " ready_pre"}, ready_b, 1'b1);
        din_b = d; msb_b = m; din_valid_b = 1'b1;
        @(negedge clk);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s sout[%0d]", tag, i), sout_b, e[i]);
            chk($sformatf("%s busy[%0d]", tag, i), busy_b, 1'b1);
            chk($sformatf("%s done[%0d]", tag, i), done_b, 1'b0);
            din_valid_b = 1'b0; din_b = 4'($urandom);
            @(negedge clk);
        end
        chk({tag, " done"}, done_b, 1'b1);
        chk({tag, " busy_end"}, busy_b, 1'b0);
        chk({tag, " ready_end"}, ready_b, 1'b1);
    endtask

    task automatic idle_a(input int n, input string tag);
        din_valid_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk($sformatf("%s sout[%0d]", tag, i), sout_a, 1'b1);
            chk($sformatf("%s busy[%0d]", tag, i), busy_a, 1'b0);
            chk($sformatf("%s done[%0d]", tag, i), done_a, 1'b0);
            chk($sformatf("%s ready[%0d]", tag, i), ready_a, 1'b1);
        end
    endtask

    initial begin
        reset_a = 1'b1; din_valid_a = 1'b0; din_a = 4'h0; msb_a = 1'b0;
        reset_b = 1'b1; din_valid_b = 1'b0; din_b = 4'h0; msb_b = 1'b0;

        // reset state, with a valid word offered that must not be taken
        @(negedge clk);
        din_valid_a = 1'b1; din_a = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rst sout_a", sout_a, 1'b1);
        chk("rst busy_a", busy_a, 1'b0);
        chk("rst done_a", done_a, 1'b0);
        chk("rst ready_a", ready_a, 1'b0);
        chk("rst sout_b", sout_b, 1'b1);
        chk("rst ready_b", ready_b, 1'b0);
        din_valid_a = 1'b0;
        reset_a = 1'b0;
        idle_a(2, "post_rst");

        // LSB first, then MSB first, with parity
        frame_a(4'b1011, 1'b0, 1'b0, 4'h0, "lsb1011");
        idle_a(1, "gap1");
        frame_a(4'b1011, 1'b1, 1'b0, 4'h0, "msb1011");
        idle_a(1, "gap2");

        // back-to-back, valid held high, din changing while busy
        frame_a(4'b1011, 1'b0, 1'b1, 4'b0000, "b2b_1");
        frame_a(4'b0000, 1'b0, 1'b1, 4'b0000, "b2b_2");
        idle_a(2, "gap3");

        // reset during DATA of 1011
        din_a = 4'b1011; msb_a = 1'b0; din_valid_a = 1'b1;
        @(negedge clk);
        din_valid_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst busy_before", busy_a, 1'b1);
        reset_a = 1'b1;
        @(negedge clk);
        chk("midrst sout", sout_a, 1'b1);
        chk("midrst busy", busy_a, 1'b0);
        chk("midrst done", done_a, 1'b0);
        chk("midrst ready_in_rst", ready_a, 1'b0);
        reset_a = 1'b0;
        idle_a(3, "after_rst");
        frame_a(4'b0001, 1'b0, 1'b0, 4'h0, "post_rst0001");

        // valid with 1111 offered only while busy: no extra frame
        frame_a(4'b0110, 1'b1, 1'b1, 4'b1111, "ignored");
        idle_a(4, "no_extra");

        // randomized frames, random order, random mid-frame noise, random gaps
        for (int t = 0; t < 12; t++) begin
            logic [3:0] d, bd;
            logic       m, bv;
            d  = 4'($urandom);
            bd = 4'($urandom);
            m  = 1'($urandom);
            bv = 1'($urandom);
            frame_a(d, m, bv, bd, $sformatf("rnd%0d", t));
            if ($urandom_range(0, 1) == 0) idle_a(1 + $urandom_range(0, 2), $sformatf("rgap%0d", t));
        end
        idle_a(1, "a_end");

        // stretched bits, no parity
        reset_b = 1'b0;
        @(negedge clk);
        frame_b(4'b0110, 1'b0, "b0110");
        for (int t = 0; t < 4; t++) begin
            frame_b(4'($urandom), 1'($urandom), $sformatf("brnd%0d", t));
        end
        din_valid_b = 1'b0;
        @(negedge clk);
        chk("b idle sout", sout_b, 1'b1);
        chk("b idle busy", busy_b, 1'b0);
        chk("b idle done", done_b, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
